// File: rtl/simple_add_example_lane_adder_if.sv
// AXI4-Stream bundle used on both sides of the lane adder.
interface simple_add_example_lane_adder_if #(
  parameter int DATA_WIDTH = 128
) ();
  logic                    tvalid;
  logic                    tready;
  logic [DATA_WIDTH-1:0]   tdata;
  logic [DATA_WIDTH/8-1:0] tkeep;
  logic                    tlast;

  modport master (output tvalid, output tdata, output tkeep, output tlast, input tready);
  modport slave  (input tvalid, input tdata, input tkeep, input tlast, output tready);
endinterface

// File: rtl/simple_add_example_lane_adder.sv
// Adds a run-time constant to every lane of a packed number stream; the output is
// a main register plus a skid register so both handshake outputs are registered.
module simple_add_example_lane_adder #(
  parameter int C_AXIS_TDATA_WIDTH = 128,
  parameter int C_NUMBER_BIT_WIDTH = 32,
  parameter int C_BEAT_COUNT_WIDTH = 32
) (
  input  logic                          aclk,
  input  logic                          areset,
  input  logic                          ap_start,
  output logic                          ap_done,
  output logic                          ap_idle,
  input  logic [C_NUMBER_BIT_WIDTH-1:0] ctrl_constant,
  simple_add_example_lane_adder_if.slave  s_axis,
  simple_add_example_lane_adder_if.master m_axis,
  output logic [C_BEAT_COUNT_WIDTH-1:0] beats_out
);
  localparam int LANES      = C_AXIS_TDATA_WIDTH / C_NUMBER_BIT_WIDTH;
  localparam int KEEP_WIDTH = C_AXIS_TDATA_WIDTH / 8;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                          state_reg, state_next;
  logic                            start_reg;
  logic [C_NUMBER_BIT_WIDTH-1:0]   constant_reg, constant_next;
  logic [C_BEAT_COUNT_WIDTH-1:0]   beats_reg, beats_next;
  logic                            last_in_reg, last_in_next;
  logic                            ready_reg, ready_next;
  logic                            done_reg, done_next;
  logic                            idle_reg, idle_next;
  logic                            main_valid_reg, main_valid_next;
  logic [C_AXIS_TDATA_WIDTH-1:0]   main_data_reg, main_data_next;
  logic [KEEP_WIDTH-1:0]           main_keep_reg, main_keep_next;
  logic                            main_last_reg, main_last_next;
  logic                            skid_valid_reg, skid_valid_next;
  logic [C_AXIS_TDATA_WIDTH-1:0]   skid_data_reg, skid_data_next;
  logic [KEEP_WIDTH-1:0]           skid_keep_reg, skid_keep_next;
  logic                            skid_last_reg, skid_last_next;
  logic [C_AXIS_TDATA_WIDTH-1:0]   sum;
  logic                            go, in_xfer, out_xfer;

  // Lanes are added independently so carries never cross a lane boundary.
  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      assign sum[gi*C_NUMBER_BIT_WIDTH +: C_NUMBER_BIT_WIDTH] =
        s_axis.tdata[gi*C_NUMBER_BIT_WIDTH +: C_NUMBER_BIT_WIDTH] + constant_reg;
    end
  endgenerate

  assign go       = ap_start & ~start_reg;
  assign in_xfer  = s_axis.tvalid & ready_reg;
  assign out_xfer = main_valid_reg & m_axis.tready;

  always_comb begin
    state_next      = state_reg;
    constant_next   = constant_reg;
    beats_next      = beats_reg;
    last_in_next    = last_in_reg;
    main_valid_next = main_valid_reg;
    main_data_next  = main_data_reg;
    main_keep_next  = main_keep_reg;
    main_last_next  = main_last_reg;
    skid_valid_next = skid_valid_reg;
    skid_data_next  = skid_data_reg;
    skid_keep_next  = skid_keep_reg;
    skid_last_next  = skid_last_reg;

    case (state_reg)
      IDLE: if (go) begin
        state_next    = RUN;
        constant_next = ctrl_constant;
        beats_next    = '0;
        last_in_next  = 1'b0;
      end
      RUN: if (out_xfer) begin
        beats_next = beats_reg + C_BEAT_COUNT_WIDTH'(1);
        if (main_last_reg) state_next = DONE;
      end
      default: state_next = IDLE;
    endcase

    if (in_xfer && s_axis.tlast) last_in_next = 1'b1;

    // Main is free when empty or draining; skid always has priority to refill it.
    if (out_xfer || !main_valid_reg) begin
      if (skid_valid_reg) begin
        main_valid_next = 1'b1;
        main_data_next  = skid_data_reg;
        main_keep_next  = skid_keep_reg;
        main_last_next  = skid_last_reg;
        skid_valid_next = 1'b0;
      end else if (in_xfer) begin
        main_valid_next = 1'b1;
        main_data_next  = sum;
        main_keep_next  = s_axis.tkeep;
        main_last_next  = s_axis.tlast;
      end else begin
        main_valid_next = 1'b0;
      end
    end else if (in_xfer) begin
      skid_valid_next = 1'b1;
      skid_data_next  = sum;
      skid_keep_next  = s_axis.tkeep;
      skid_last_next  = s_axis.tlast;
    end

    ready_next = (state_next == RUN) && !skid_valid_next && !last_in_next;
    done_next  = (state_next == DONE);
    idle_next  = (state_next == IDLE);
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_reg      <= IDLE;
      start_reg      <= 1'b0;
      constant_reg   <= '0;
      beats_reg      <= '0;
      last_in_reg    <= 1'b0;
      ready_reg      <= 1'b0;
      done_reg       <= 1'b0;
      idle_reg       <= 1'b1;
      main_valid_reg <= 1'b0;
      main_data_reg  <= '0;
      main_keep_reg  <= '0;
      main_last_reg  <= 1'b0;
      skid_valid_reg <= 1'b0;
      skid_data_reg  <= '0;
      skid_keep_reg  <= '0;
      skid_last_reg  <= 1'b0;
    end else begin
      state_reg      <= state_next;
      start_reg      <= ap_start;
      constant_reg   <= constant_next;
      beats_reg      <= beats_next;
      last_in_reg    <= last_in_next;
      ready_reg      <= ready_next;
      done_reg       <= done_next;
      idle_reg       <= idle_next;
      main_valid_reg <= main_valid_next;
      main_data_reg  <= main_data_next;
      main_keep_reg  <= main_keep_next;
      main_last_reg  <= main_last_next;
      skid_valid_reg <= skid_valid_next;
      skid_data_reg  <= skid_data_next;
      skid_keep_reg  <= skid_keep_next;
      skid_last_reg  <= skid_last_next;
    end
  end

  assign s_axis.tready = ready_reg;
  assign m_axis.tvalid = main_valid_reg;
  assign m_axis.tdata  = main_data_reg;
  assign m_axis.tkeep  = main_keep_reg;
  assign m_axis.tlast  = main_last_reg;
  assign ap_done       = done_reg;
  assign ap_idle       = idle_reg;
  assign beats_out     = beats_reg;
endmodule

// File: tb/tb_simple_add_example_lane_adder.sv
// Directed and randomized checks of the lane adder against a queue-based lane-sum model.
module tb_simple_add_example_lane_adder;
  logic        aclk = 1'b0;
  logic        areset;
  logic        ap_start;
  logic        ap_done;
  logic        ap_idle;
  logic [31:0] ctrl_constant;
  logic [31:0] beats_out;

  simple_add_example_lane_adder_if #(.DATA_WIDTH(128)) s_if ();
  simple_add_example_lane_adder_if #(.DATA_WIDTH(128)) m_if ();

  simple_add_example_lane_adder dut (
    .aclk(aclk), .areset(areset), .ap_start(ap_start), .ap_done(ap_done), .ap_idle(ap_idle),
    .ctrl_constant(ctrl_constant), .s_axis(s_if), .m_axis(m_if), .beats_out(beats_out)
  );

  always #5 aclk = ~aclk;

  typedef struct {
    logic [127:0] d;
    logic [15:0]  k;
    logic         l;
  } beat_t;

  beat_t        exp_q[$];
  int           checks = 0;
  int           errors = 0;
  logic [127:0] last_out;
  logic [15:0]  last_keep_out;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] model_add(input logic [127:0] d, input logic [31:0] c);
    logic [127:0] r;
    for (int i = 0; i < 4; i++) r[i*32 +: 32] = d[i*32 +: 32] + c;
    return r;
  endfunction

  function automatic logic [127:0] gen_data(input int mode, input int idx);
    logic [127:0] r;
    case (mode)
      0: for (int i = 0; i < 4; i++) r[i*32 +: 32] = 32'(4 * idx + i);
      1: r = {$urandom, $urandom, $urandom, $urandom};
      default: r = {32'(idx), 32'hFFFF_FFFE, 32'(16 + idx), 32'hFFFF_FFFF};
    endcase
    return r;
  endfunction

  task automatic start_run(input logic [31:0] c, input bit hold);
    @(negedge aclk);
    ctrl_constant = c;
    ap_start = 1'b1;
    @(negedge aclk);
    if (!hold) ap_start = 1'b0;
    ctrl_constant = $urandom;
    check("start_idle", ap_idle, 0);
    check("start_beats", beats_out, 0);
  endtask

  task automatic run_stream(input int n, input logic [31:0] c, input int mode, input int p_valid,
                            input int p_ready, input int stall_s, input int stall_l,
                            input logic [15:0] last_keep, input bit full_tp);
    int idx = 0, emitted = 0, cyc = 0;
    bit last_in = 0, done_exp = 0, prev_stall = 0, prev_in = 0, in_x, out_x;
    logic [127:0] prev_data = '0;
    beat_t e;
    s_if.tvalid = 1'b0;
    while (cyc < n * 20 + 100) begin
      check("ap_done", ap_done, done_exp);
      if (done_exp) break;
      check("m_tvalid", m_if.tvalid, exp_q.size() > 0);
      check("s_tready", s_if.tready, exp_q.size() < 2 && !last_in);
      if (prev_stall) check("hold_data", m_if.tdata, prev_data);
      if (full_tp && prev_in) check("latency", m_if.tvalid, 1);
      if (!s_if.tvalid || prev_in) begin
        if (idx < n && $urandom_range(99) < p_valid) begin
          s_if.tvalid = 1'b1;
          s_if.tdata  = gen_data(mode, idx);
          s_if.tkeep  = (idx == n - 1) ? last_keep : 16'hFFFF;
          s_if.tlast  = (idx == n - 1);
        end else begin
          s_if.tvalid = 1'b0;
        end
      end
      m_if.tready = (cyc >= stall_s && cyc < stall_s + stall_l) ? 1'b0
                    : ($urandom_range(99) < p_ready);
      in_x  = s_if.tvalid && s_if.tready;
      out_x = m_if.tvalid && m_if.tready;
      if (out_x) begin
        if (exp_q.size() == 0) begin
          check("spurious_out", exp_q.size(), 1);
        end else begin
          e = exp_q.pop_front();
          check("tdata", m_if.tdata, e.d);
          check("tkeep", m_if.tkeep, e.k);
          check("tlast", m_if.tlast, e.l);
          done_exp = e.l;
        end
        last_out = m_if.tdata;
        last_keep_out = m_if.tkeep;
        emitted++;
      end
      if (in_x) begin
        exp_q.push_back('{model_add(s_if.tdata, c), s_if.tkeep, s_if.tlast});
        if (s_if.tlast) last_in = 1;
        idx++;
      end
      prev_stall = m_if.tvalid && !m_if.tready;
      prev_data  = m_if.tdata;
      prev_in    = in_x;
      cyc++;
      @(negedge aclk);
    end
    s_if.tvalid = 1'b0;
    check("emitted", emitted, n);
    check("beats_out", beats_out, n);
    @(negedge aclk);
    check("done_one_pulse", ap_done, 0);
    check("idle_after", ap_idle, 1);
  endtask

  initial begin
    areset = 1'b1; ap_start = 1'b0; ctrl_constant = '0;
    s_if.tvalid = 1'b0; s_if.tdata = '0; s_if.tkeep = '0; s_if.tlast = 1'b0;
    m_if.tready = 1'b0;
    #1;
    check("rst_s_tready", s_if.tready, 0);
    check("rst_m_tvalid", m_if.tvalid, 0);
    check("rst_ap_done", ap_done, 0);
    check("rst_ap_idle", ap_idle, 1);
    check("rst_beats", beats_out, 0);
    repeat (3) @(negedge aclk);
    areset = 1'b0;

    // Basic run: constant 5, 4 sequential beats, full throughput.
    start_run(32'd5, 0);
    run_stream(4, 32'd5, 0, 100, 100, -1, 0, 16'hFFFF, 1);
    check("basic_lane0", last_out[31:0], 32'd17);

    // Per-lane wrap without carry into neighbours.
    start_run(32'h2, 0);
    run_stream(2, 32'h2, 2, 100, 100, -1, 0, 16'hFFFF, 1);
    check("wrap_lane0", last_out[31:0], 32'h1);
    check("wrap_lane1", last_out[63:32], 32'h13);
    check("wrap_lane2", last_out[95:64], 32'h0);

    // Backpressure for 5 cycles mid-stream.
    start_run(32'h77, 0);
    run_stream(8, 32'h77, 1, 100, 100, 3, 5, 16'hFFFF, 0);

    // Long randomized handshake run with partial tkeep on the last beat.
    start_run(32'h1234, 0);
    run_stream(1024, 32'h1234, 1, 70, 60, -1, 0, 16'h00FF, 0);
    check("final_keep", last_keep_out, 16'h00FF);

    // ap_start held high: only one run, then a new edge restarts the counter.
    start_run(32'h9, 1);
    run_stream(5, 32'h9, 1, 100, 100, -1, 0, 16'hFFFF, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge aclk);
      check("hold_no_rerun_idle", ap_idle, 1);
      check("hold_no_rerun_ready", s_if.tready, 0);
    end
    ap_start = 1'b0;
    start_run(32'hA, 0);
    run_stream(3, 32'hA, 0, 100, 100, -1, 0, 16'hFFFF, 0);

    // Reset mid-run with both buffer entries occupied.
    start_run(32'h7, 0);
    m_if.tready = 1'b0;
    s_if.tvalid = 1'b1; s_if.tkeep = 16'hFFFF; s_if.tlast = 1'b0;
    s_if.tdata = gen_data(0, 0);
    @(negedge aclk);
    s_if.tdata = gen_data(0, 1);
    @(negedge aclk);
    s_if.tvalid = 1'b0;
    check("buf_full_valid", m_if.tvalid, 1);
    check("buf_full_ready", s_if.tready, 0);
    #2 areset = 1'b1;
    #1;
    check("arst_m_tvalid", m_if.tvalid, 0);
    check("arst_s_tready", s_if.tready, 0);
    check("arst_ap_idle", ap_idle, 1);
    @(negedge aclk);
    areset = 1'b0;
    m_if.tready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge aclk);
      check("arst_no_done", ap_done, 0);
      check("arst_no_out", m_if.tvalid, 0);
    end
    check("arst_beats", beats_out, 0);
    exp_q.delete();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/simple_add_example_lane_adder.md
Name: simple_add_example_lane_adder

Overview:
- Downstream stage of the kernel's number generator.
- Consumes the AXI4-Stream of packed 32-bit numbers and adds a run-time constant to every lane (modulo 2^C_NUMBER_BIT_WIDTH).
- Emits the result as a registered AXI4-Stream with a 2-entry skid buffer, so both tready and tvalid are register-driven.
- Provides ap_start/ap_done control and a beat counter for the kernel control block.

Parameters:
- C_AXIS_TDATA_WIDTH, 128, stream data width in bits; must be a multiple of C_NUMBER_BIT_WIDTH.
- C_NUMBER_BIT_WIDTH, 32, width of one lane; a lane is one number.
- C_BEAT_COUNT_WIDTH, 32, width of the beats_out status counter.

Ports:
- aclk  in  1  clock.
- areset  in  1  asynchronous, active-high reset.
- ap_start  in  1  level; rising edge starts a run.
- ap_done  out  1  one-cycle pulse when the output tlast beat is accepted.
- ap_idle  out  1  high when in IDLE.
- ctrl_constant  in  C_NUMBER_BIT_WIDTH  addend, sampled on the start edge.
- s_axis_tvalid  in  1  input valid.
- s_axis_tready  out  1  input ready (registered).
- s_axis_tdata  in  C_AXIS_TDATA_WIDTH  input lanes.
- s_axis_tkeep  in  C_AXIS_TDATA_WIDTH/8  input byte enables.
- s_axis_tlast  in  1  input last beat.
- m_axis_tvalid  out  1  output valid (registered).
- m_axis_tready  in  1  output ready.
- m_axis_tdata  out  C_AXIS_TDATA_WIDTH  output lanes.
- m_axis_tkeep  out  C_AXIS_TDATA_WIDTH/8  output byte enables, passed through.
- m_axis_tlast  out  1  output last beat, passed through.
- beats_out  out  C_BEAT_COUNT_WIDTH  count of output beats accepted in the current run.

Behaviour:
- Reset:
  - areset asynchronously clears all registers.
  - State is IDLE; s_axis_tready=0, m_axis_tvalid=0, ap_done=0, ap_idle=1, beats_out=0.
  - Both skid entries are invalid; the latched constant is 0; ap_start_r=0.
  - Reset mid-run discards any buffered beats; nothing further is emitted.
- Start detection: go = ap_start & ~ap_start_r, with ap_start_r registered each cycle. go outside IDLE is ignored.
- State machine:
  - IDLE -> RUN on go: latch ctrl_constant and clear beats_out.
  - RUN -> DONE on the cycle an output beat with m_axis_tlast=1 transfers (m_axis_tvalid & m_axis_tready).
  - DONE -> IDLE unconditionally after one cycle.
  - ap_done=1 exactly in DONE, i.e. registered, one cycle after the tlast transfer.
- Arithmetic:
  - Lane i output = s_axis_tdata lane i + latched constant, truncated to C_NUMBER_BIT_WIDTH.
  - Carries never cross lanes.
  - All lanes are added regardless of tkeep; tkeep and tlast are carried unchanged alongside the data.
- Datapath:
  - Output register (main) plus one skid register.
  - s_axis_tready is 1 in RUN only while the skid entry is empty; it is 0 in IDLE and DONE.
  - Input transfer is s_axis_tvalid & s_axis_tready. The sum is computed combinationally from s_axis_tdata and written into main if main is empty or draining this cycle, otherwise into skid.
  - Latency: a beat accepted at cycle N is presented on m_axis at N+1 when main was empty or draining.
  - When main drains and skid is full, skid moves to main the same cycle and skid empties; s_axis_tready returns to 1 the next cycle.
  - m_axis_tvalid and tdata are held stable while m_axis_tready=0 (AXI rule).
  - Simultaneous input accept and output drain with the skid empty: the new beat goes into main, which stays valid.
- Input acceptance stops after tlast: once a beat with s_axis_tlast=1 has been accepted, s_axis_tready=0 for the remainder of the run.
- beats_out increments on each output transfer in RUN. It wraps modulo 2^C_BEAT_COUNT_WIDTH and holds its value in IDLE until the next go.
- Full throughput (one beat per cycle) when m_axis_tready is held at 1.

Test Plan:
- Start with ctrl_constant=5, then feed 4 beats {3,2,1,0},{7,6,5,4},... with the last carrying tlast and m_axis_tready=1 -> outputs {8,7,6,5},{12,11,10,9},... each 1 cycle after input; ap_done pulses once, 1 cycle after the 4th output; beats_out=4.
- Wrap: ctrl_constant=0x00000002, lane value 0xFFFFFFFF -> output lane 0x00000001; neighbouring lane unaffected (no carry).
- Backpressure: m_axis_tready=0 for 5 cycles mid-stream -> at most 2 beats buffered; s_axis_tready drops the cycle after skid fills; m_axis_tdata stable; no beat lost or duplicated after release.
- Random tvalid/tready toggling over 1024 beats, constant=0x1234 -> output equals input+0x1234 in order; tkeep/tlast of the final beat (e.g. tkeep=0x00FF) preserved.
- ap_start held high across a whole run -> no second run; a new rising edge after ap_done starts a new run and beats_out restarts from 0.
- areset asserted mid-run with 2 beats buffered -> m_axis_tvalid=0 and s_axis_tready=0 immediately (asynchronously); ap_idle=1; no ap_done pulse.
